// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter: state encoding and default sizes.
package i2s_pkg;

    // One-hot sequencing states; any other pattern is illegal and recovers to IDLE.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        LOAD  = 4'b0010,
        LEFT  = 4'b0100,
        RIGHT = 4'b1000
    } state_t;

    localparam int DEF_DATA_W    = 24;
    localparam int DEF_SLOT_BITS = 32;
    localparam int DEF_SCLK_DIV  = 4;

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: produces SCLK and a one-clk pulse in the cycle whose
// closing edge makes SCLK fall. Held at count 0 (SCLK low) while clear_i is high.
module i2s_sclk_gen #(
    parameter int SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic sclk_o,
    output logic sclkFall_o
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(SCLK_DIV / 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sclk_q;

    // Next divider count: wraps at SCLK_DIV-1, forced to zero by clear.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // SCLK is registered from the next count so it never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= (cnt_d >= CNT_HALF);
        end
    end

    assign sclk_o     = sclk_q;
    assign sclkFall_o = ~clear_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: takes left/right pairs over valid/ready, holds one pair in
// reserve, and shifts each frame out MSB-first with the standard one-bit delay.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int SCLK_DIV  = DEF_SCLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rht_in,
    input  logic              smpl_vld,
    output logic              smpl_rdy,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              SDout,
    output logic              frm_strt,
    output logic              underrun
);

    localparam int BCW = $clog2(2 * SLOT_BITS);
    localparam logic [BCW-1:0] BIT_LAST    = BCW'(2 * SLOT_BITS - 1);
    localparam logic [BCW-1:0] BIT_SLOT    = BCW'(SLOT_BITS);
    localparam logic [BCW-1:0] BIT_L_FIRST = BCW'(1);
    localparam logic [BCW-1:0] BIT_L_LAST  = BCW'(DATA_W);
    localparam logic [BCW-1:0] BIT_R_FIRST = BCW'(SLOT_BITS + 1);
    localparam logic [BCW-1:0] BIT_R_LAST  = BCW'(SLOT_BITS + DATA_W);

    state_t            state_q;
    logic [BCW-1:0]    bitCnt_q;
    logic [BCW-1:0]    bitCnt_d;
    logic              lrclk_q;
    logic              sdout_q;
    logic              frmStrt_q;
    logic              underrun_q;
    logic              holdFull_q;
    logic [DATA_W-1:0] holdL_q;
    logic [DATA_W-1:0] holdR_q;
    logic [DATA_W-1:0] leftSh_q;
    logic [DATA_W-1:0] rightSh_q;

    logic accept;
    logic divClear;
    logic sclkFall;
    logic sclk;
    logic inLeftData;
    logic inRightData;
    logic lastBit;

    // The divider only runs while a slot is being shifted; IDLE and LOAD hold SCLK low.
    i2s_sclk_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) uSclkGen (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (divClear),
        .sclk_o    (sclk),
        .sclkFall_o(sclkFall)
    );

    // Bit-position decode for the position about to start at the next SCLK fall.
    always_comb begin
        accept      = smpl_vld & ~holdFull_q;
        divClear    = ~((state_q == LEFT) | (state_q == RIGHT));
        bitCnt_d    = bitCnt_q + BCW'(1);
        lastBit     = (bitCnt_q == BIT_LAST);
        inLeftData  = (bitCnt_d >= BIT_L_FIRST) && (bitCnt_d <= BIT_L_LAST);
        inRightData = (bitCnt_d >= BIT_R_FIRST) && (bitCnt_d <= BIT_R_LAST);
    end

    // Sequencer with registered outputs, holding register and both shifters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            lrclk_q    <= 1'b1;
            sdout_q    <= 1'b0;
            frmStrt_q  <= 1'b0;
            underrun_q <= 1'b0;
            holdFull_q <= 1'b0;
            holdL_q    <= '0;
            holdR_q    <= '0;
            leftSh_q   <= '0;
            rightSh_q  <= '0;
        end else begin
            frmStrt_q  <= 1'b0;
            underrun_q <= 1'b0;

            if (accept && (state_q != LOAD)) begin
                holdL_q    <= lft_in;
                holdR_q    <= rht_in;
                holdFull_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    lrclk_q  <= 1'b1;
                    sdout_q  <= 1'b0;
                    bitCnt_q <= '0;
                    if (en) begin
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    if (holdFull_q) begin
                        leftSh_q   <= holdL_q;
                        rightSh_q  <= holdR_q;
                        holdFull_q <= 1'b0;
                    end else if (accept) begin
                        leftSh_q  <= lft_in;
                        rightSh_q <= rht_in;
                    end else begin
                        leftSh_q   <= '0;
                        rightSh_q  <= '0;
                        underrun_q <= 1'b1;
                    end
                    frmStrt_q <= 1'b1;
                    bitCnt_q  <= '0;
                    lrclk_q   <= 1'b0;
                    sdout_q   <= 1'b0;
                    state_q   <= LEFT;
                end

                LEFT, RIGHT: begin
                    if (sclkFall) begin
                        if ((state_q == RIGHT) && lastBit) begin
                            bitCnt_q <= '0;
                            lrclk_q  <= 1'b1;
                            sdout_q  <= 1'b0;
                            state_q  <= en ? LOAD : IDLE;
                        end else begin
                            bitCnt_q <= bitCnt_d;
                            lrclk_q  <= (bitCnt_d >= BIT_SLOT);
                            if ((state_q == LEFT) && (bitCnt_d == BIT_SLOT)) begin
                                state_q <= RIGHT;
                            end
                            if (inLeftData) begin
                                sdout_q  <= leftSh_q[DATA_W-1];
                                leftSh_q <= {leftSh_q[DATA_W-2:0], 1'b0};
                            end else if (inRightData) begin
                                sdout_q   <= rightSh_q[DATA_W-1];
                                rightSh_q <= {rightSh_q[DATA_W-2:0], 1'b0};
                            end else begin
                                sdout_q <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    bitCnt_q <= '0;
                    lrclk_q  <= 1'b1;
                    sdout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign smpl_rdy = ~holdFull_q;
    assign SCLK     = sclk;
    assign LRCLK    = lrclk_q;
    assign SDout    = sdout_q;
    assign frm_strt = frmStrt_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with the default 24-bit / 32-slot / divide-by-4 setup.
module tb_i2s_tx;

    logic        clk;
    logic        rst;
    logic        en;
    logic [23:0] lft_in;
    logic [23:0] rht_in;
    logic        smpl_vld;
    logic        smpl_rdy;
    logic        SCLK;
    logic        LRCLK;
    logic        SDout;
    logic        frm_strt;
    logic        underrun;

    int assertCount = 0;
    int failCount   = 0;
    int cycleCount  = 0;
    int lastStart   = 0;

    i2s_tx #(
        .DATA_W   (24),
        .SLOT_BITS(32),
        .SCLK_DIV (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .smpl_vld(smpl_vld),
        .smpl_rdy(smpl_rdy),
        .SCLK    (SCLK),
        .LRCLK   (LRCLK),
        .SDout   (SDout),
        .frm_strt(frm_strt),
        .underrun(underrun)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter for period measurements.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [23:0] l, input logic [23:0] r);
        smpl_vld = vld;
        lft_in   = l;
        rht_in   = r;
    endtask

    // Waits for frm_strt, then follows one frame sampling SDout/LRCLK on each SCLK rise.
    // Optionally preloads the next pair, drops en at a bit position, or stops early.
    task automatic captureFrame(input string name, input bit doPreload,
                                input logic [23:0] pl, input logic [23:0] pr,
                                input int dropEnPos, input int stopPos,
                                input logic [23:0] expL, input logic [23:0] expR,
                                input logic expUnderrun, output bit stopped);
        logic       bits [64];
        bit         found;
        int         pos, lastRise, badSpacing, badChange, extraStrt, extraUnd, lrBad, highCount;
        logic       prevSclk, prevSd, prevLr;
        logic [23:0] gotL, gotR;
        logic       pad;
        found = 1'b0; stopped = 1'b0;
        pos = 0; lastRise = 0; badSpacing = 0; badChange = 0;
        extraStrt = 0; extraUnd = 0; lrBad = 0; highCount = 0;
        for (int c = 0; c < 600; c++) begin
            if (frm_strt === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({name, "_frmStrtSeen"}, 32'(found), 32'd1);
        if (!found) return;
        lastStart = cycleCount;
        checkOutput({name, "_underrun"}, 32'(underrun), 32'(expUnderrun));
        checkOutput({name, "_lrclkStart"}, 32'(LRCLK), 32'd0);
        prevSclk = SCLK; prevSd = SDout; prevLr = LRCLK;
        for (int off = 0; off < 256; off++) begin
            if (off > 0) begin
                @(negedge clk);
                if (((SDout !== prevSd) || (LRCLK !== prevLr)) && !(prevSclk === 1'b1 && SCLK === 1'b0))
                    badChange++;
                if (frm_strt !== 1'b0) extraStrt++;
                if (underrun !== 1'b0) extraUnd++;
            end
            if (SCLK === 1'b1) highCount++;
            if (doPreload && off == 4) begin
                checkOutput({name, "_rdyBeforePreload"}, 32'(smpl_rdy), 32'd1);
                applyStimulus(1'b1, pl, pr);
            end
            if (doPreload && off == 5) begin
                applyStimulus(1'b0, 24'h0, 24'h0);
                checkOutput({name, "_rdyAfterPreload"}, 32'(smpl_rdy), 32'd0);
            end
            if (SCLK === 1'b1 && prevSclk === 1'b0) begin
                if (pos > 0 && (off - lastRise) != 4) badSpacing++;
                lastRise = off;
                bits[pos] = SDout;
                if (LRCLK !== ((pos >= 32) ? 1'b1 : 1'b0)) lrBad++;
                if (pos == dropEnPos) en = 1'b0;
                if (pos == stopPos) begin
                    stopped = 1'b1;
                    return;
                end
                pos++;
            end
            prevSclk = SCLK; prevSd = SDout; prevLr = LRCLK;
        end
        gotL = '0; gotR = '0; pad = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            gotL = {gotL[22:0], bits[k]};
            gotR = {gotR[22:0], bits[32+k]};
        end
        for (int k = 0; k < 64; k++) begin
            if ((k == 0) || (k >= 25 && k <= 32) || (k >= 57)) pad = pad | bits[k];
        end
        checkOutput({name, "_riseCount"}, 32'(pos), 32'd64);
        checkOutput({name, "_sclkSpacing"}, 32'(badSpacing), 32'd0);
        checkOutput({name, "_sclkHighCycles"}, 32'(highCount), 32'd128);
        checkOutput({name, "_changeOnFall"}, 32'(badChange), 32'd0);
        checkOutput({name, "_lrclkPattern"}, 32'(lrBad), 32'd0);
        checkOutput({name, "_singleStrt"}, 32'(extraStrt), 32'd0);
        checkOutput({name, "_singleUnderrun"}, 32'(extraUnd), 32'd0);
        checkOutput({name, "_leftWord"}, 32'(gotL), 32'(expL));
        checkOutput({name, "_rightWord"}, 32'(gotR), 32'(expR));
        checkOutput({name, "_padding"}, 32'(pad), 32'd0);
    endtask

    // Linear directed sequence covering reset, underrun, forwarding, en drop and mid-frame reset.
    initial begin
        bit stopped;
        int start1, start2, idleActivity;
        rst = 1'b1;
        en  = 1'b1;
        applyStimulus(1'b1, 24'hA5A5A5, 24'h3C3C3C);
        repeat (3) @(negedge clk);
        checkOutput("reset_SCLK", 32'(SCLK), 32'd0);
        checkOutput("reset_LRCLK", 32'(LRCLK), 32'd1);
        checkOutput("reset_SDout", 32'(SDout), 32'd0);
        checkOutput("reset_rdy", 32'(smpl_rdy), 32'd1);
        checkOutput("reset_frmStrt", 32'(frm_strt), 32'd0);
        checkOutput("reset_underrun", 32'(underrun), 32'd0);

        // Frame 1: pair preloaded while still in IDLE.
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t1_rdyAfterAccept", 32'(smpl_rdy), 32'd0);
        checkOutput("t1_frmStrtEarly", 32'(frm_strt), 32'd0);
        checkOutput("t1_lrclkInLoad", 32'(LRCLK), 32'd1);
        applyStimulus(1'b0, 24'h0, 24'h0);
        @(negedge clk);
        checkOutput("t1_frmStrt2clk", 32'(frm_strt), 32'd1);
        checkOutput("t1_rdyAfterLoad", 32'(smpl_rdy), 32'd1);
        captureFrame("f1", 1'b0, 24'h0, 24'h0, -1, -1, 24'hA5A5A5, 24'h3C3C3C, 1'b0, stopped);
        start1 = lastStart;

        // Frame 2: nothing pending, so zeros and an underrun.
        captureFrame("f2", 1'b0, 24'h0, 24'h0, -1, -1, 24'h000000, 24'h000000, 1'b1, stopped);
        start2 = lastStart;
        checkOutput("t2_lrclkPeriod", 32'(start2 - start1), 32'd257);
        checkOutput("t2_rdyStays", 32'(smpl_rdy), 32'd1);

        // Frame 3: pair offered during the LOAD clk itself is forwarded.
        @(negedge clk);
        checkOutput("t3_inLoadNoStrt", 32'(frm_strt), 32'd0);
        checkOutput("t3_rdyInLoad", 32'(smpl_rdy), 32'd1);
        applyStimulus(1'b1, 24'h123456, 24'hABCDEF);
        @(negedge clk);
        applyStimulus(1'b0, 24'h0, 24'h0);
        checkOutput("t3_rdyAfterForward", 32'(smpl_rdy), 32'd1);
        captureFrame("f3", 1'b1, 24'hC0FFEE, 24'h800001, -1, -1, 24'h123456, 24'hABCDEF, 1'b0, stopped);

        // Frame 4: en dropped at bit 10; frame still completes, then IDLE.
        captureFrame("f4", 1'b0, 24'h0, 24'h0, 10, -1, 24'hC0FFEE, 24'h800001, 1'b0, stopped);
        @(negedge clk);
        checkOutput("t4_idleSCLK", 32'(SCLK), 32'd0);
        checkOutput("t4_idleLRCLK", 32'(LRCLK), 32'd1);
        checkOutput("t4_idleSDout", 32'(SDout), 32'd0);
        idleActivity = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (SCLK !== 1'b0 || LRCLK !== 1'b1 || frm_strt !== 1'b0 || SDout !== 1'b0) idleActivity++;
        end
        checkOutput("t4_idleQuiet", 32'(idleActivity), 32'd0);
        applyStimulus(1'b1, 24'h5A5A5A, 24'hFFFFFF);
        @(negedge clk);
        checkOutput("t4_idlePreloadRdy", 32'(smpl_rdy), 32'd0);
        applyStimulus(1'b0, 24'h0, 24'h0);
        en = 1'b1;
        captureFrame("f5", 1'b1, 24'h654321, 24'h010000, -1, -1, 24'h5A5A5A, 24'hFFFFFF, 1'b0, stopped);

        // Frame 6: reset asserted at bit 40 while the holding register is full.
        captureFrame("f6", 1'b1, 24'h777777, 24'h888888, -1, 40, 24'h0, 24'h0, 1'b0, stopped);
        checkOutput("t5_reachedBit40", 32'(stopped), 32'd1);
        checkOutput("t5_sclkHighBefore", 32'(SCLK), 32'd1);
        checkOutput("t5_bit40Data", 32'(SDout), 32'd1);
        checkOutput("t5_rdyLowBefore", 32'(smpl_rdy), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("t5_rstSCLK", 32'(SCLK), 32'd0);
        checkOutput("t5_rstLRCLK", 32'(LRCLK), 32'd1);
        checkOutput("t5_rstSDout", 32'(SDout), 32'd0);
        checkOutput("t5_rstRdy", 32'(smpl_rdy), 32'd1);
        checkOutput("t5_rstFrmStrt", 32'(frm_strt), 32'd0);
        checkOutput("t5_rstUnderrun", 32'(underrun), 32'd0);
        applyStimulus(1'b1, 24'h9ABCDE, 24'h13579B);
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 24'h0, 24'h0);
        checkOutput("t5_rdyAfterAccept", 32'(smpl_rdy), 32'd0);
        @(negedge clk);
        checkOutput("t5_frmStrt2clk", 32'(frm_strt), 32'd1);
        captureFrame("f7", 1'b0, 24'h0, 24'h0, -1, -1, 24'h9ABCDE, 24'h13579B, 1'b0, stopped);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
